// File: rtl/serv_mac_seq_pkg.sv
// Shared definitions for the SERV multi-step MAC loop sequencer.
// Holds the loop state encoding and the PC offset helpers derived from NSTEP.
package serv_mac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } mac_state_e;

    localparam int INSN_BYTES = 4;

    // PC displacement serv_ctrl applies for a loop-back from the last step
    function automatic int back_bytes(input int nstep);
        return INSN_BYTES * (nstep - 1);
    endfunction

    // PC displacement serv_ctrl applies to jump past the whole body
    function automatic int skip_bytes(input int nstep);
        return INSN_BYTES * nstep;
    endfunction

    function automatic int load_slots(input int cw, input int w);
        return (cw + w - 1) / w;
    endfunction

endpackage

// File: rtl/serv_mac_seq_cnt_load.sv
// Serial W-bit loader for the loop count: LSB-first shift-in over ceil(CW/W) slots,
// with a strobe in the slot that completes the CW-bit value.
module serv_mac_seq_cnt_load
    import serv_mac_seq_pkg::*;
#(
    parameter int W  = 1,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          en,
    input  logic          cnt0,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] load_val,
    output logic          load_stb
);

    localparam int NSLOT = load_slots(CW, W);
    localparam int PW    = $clog2(NSLOT + 1);
    localparam int AW    = NSLOT * W;

    logic [PW-1:0] pos_q;
    logic [PW-1:0] slot;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic          wr;

    // Slots beyond the last kept one are ignored, so high rs1 bits never land
    always_comb begin
        slot     = cnt0 ? '0 : pos_q;
        wr       = en && (int'(slot) < NSLOT);
        acc_d    = acc_q;
        if (wr) begin
            acc_d[int'(slot) * W +: W] = din;
        end
        load_stb = wr && (int'(slot) == NSLOT - 1);
        load_val = acc_d[CW-1:0];
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            pos_q <= '0;
        end else if (wr) begin
            pos_q <= slot + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/serv_mac_seq.sv
// Loop sequencer for NSTEP-instruction MAC bodies in the bit-serial SERV core.
// Loads the pass count from rs1 on first entry and steers serv_ctrl's PC each pass.
module serv_mac_seq
    import serv_mac_seq_pkg::*;
#(
    parameter int W     = 1,
    parameter int CW    = 8,
    parameter int NSTEP = 2
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_mac_first,
    input  logic          i_mac_last,
    input  logic          i_init,
    input  logic          i_cnt_en,
    input  logic          i_cnt0,
    input  logic          i_cnt_done,
    input  logic          i_alu_cmp,
    input  logic [W-1:0]  i_rs1,
    input  logic          i_abort,
    output logic          o_pc_plus0,
    output logic          o_pc_back,
    output logic          o_pc_skip,
    output logic          o_active,
    output logic [CW-1:0] o_iter
);

    localparam int BACK_BYTES = back_bytes(NSTEP);
    localparam int SKIP_BYTES = skip_bytes(NSTEP);

    if (BACK_BYTES < INSN_BYTES || SKIP_BYTES != BACK_BYTES + INSN_BYTES) begin : g_nstep_check
        $error("serv_mac_seq: NSTEP must be at least 2");
    end

    mac_state_e    state_q;
    mac_state_e    state_d;
    logic [CW-1:0] iter_q;
    logic [CW-1:0] iter_d;
    logic          cmp_q;
    logic          cmp_d;

    logic          step_first;
    logic          step_last;
    logic          exec_ph;
    logic          ld_en;
    logic          ld_stb;
    logic [CW-1:0] ld_val;

    // A body of one step is not a legal loop, so first&last together decodes as neither
    assign step_first = i_mac_first & ~i_mac_last;
    assign step_last  = i_mac_last & ~i_mac_first;
    assign exec_ph    = ~i_init;
    assign ld_en      = (state_q == ST_IDLE) && step_first && i_init && i_cnt_en && !i_abort;

    serv_mac_seq_cnt_load #(
        .W  (W),
        .CW (CW)
    ) u_cnt_load (
        .clk      (clk),
        .i_rst    (i_rst),
        .en       (ld_en),
        .cnt0     (i_cnt0),
        .din      (i_rs1),
        .load_val (ld_val),
        .load_stb (ld_stb)
    );

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        cmp_d      = cmp_q;
        o_pc_plus0 = 1'b0;
        o_pc_back  = 1'b0;
        o_pc_skip  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ld_stb) begin
                    iter_d = ld_val;
                end
                if (step_first && i_init && i_cnt_done) begin
                    state_d = ST_ARM;
                end
            end

            // Execute phase of the loading step 1: re-run it armed, or skip an empty loop
            ST_ARM: begin
                if (step_first && exec_ph) begin
                    if (iter_q == '0) begin
                        o_pc_skip = 1'b1;
                        if (i_cnt_done) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        o_pc_plus0 = 1'b1;
                        if (i_cnt_done) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end

            ST_RUN: begin
                if (step_first && i_init) begin
                    if (i_cnt_en) begin
                        cmp_d = i_alu_cmp;
                    end else if (i_cnt0) begin
                        cmp_d = 1'b0;
                    end
                end

                if (step_first && exec_ph && cmp_q) begin
                    o_pc_skip = 1'b1;
                    if (i_cnt_done) begin
                        state_d = ST_IDLE;
                        iter_d  = '0;
                        cmp_d   = 1'b0;
                    end
                end else if (step_last && exec_ph) begin
                    if (iter_q > CW'(1)) begin
                        o_pc_back = 1'b1;
                        if (i_cnt_done) begin
                            iter_d = iter_q - CW'(1);
                        end
                    end else if (i_cnt_done) begin
                        state_d = ST_IDLE;
                        iter_d  = '0;
                        cmp_d   = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A taken trap cancels the loop and silences PC steering in the same cycle
        if (i_abort) begin
            state_d    = ST_IDLE;
            iter_d     = '0;
            cmp_d      = 1'b0;
            o_pc_plus0 = 1'b0;
            o_pc_back  = 1'b0;
            o_pc_skip  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            cmp_q   <= cmp_d;
        end
    end

    assign o_active = (state_q != ST_IDLE);
    assign o_iter   = iter_q;

endmodule

// File: tb/tb_serv_mac_seq.sv
// Bench for serv_mac_seq: W=1 and W=4 instances share one instruction stream and are
// compared against an instruction-level model of the loop semantics.
module tb_serv_mac_seq;

    localparam int CW = 8;
    localparam int NS = 12;
    localparam logic [2:0] PC_NONE  = 3'b000;
    localparam logic [2:0] PC_PLUS0 = 3'b100;
    localparam logic [2:0] PC_BACK  = 3'b010;
    localparam logic [2:0] PC_SKIP  = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mac_first = 1'b0, mac_last = 1'b0, init = 1'b0;
    logic cnt_en = 1'b0, cnt0 = 1'b0, cnt_done = 1'b0;
    logic alu_cmp = 1'b0, abort = 1'b0;
    logic rs1_1 = 1'b0;
    logic [3:0] rs1_4 = 4'd0;

    logic a_plus0, a_back, a_skip, a_active;
    logic [CW-1:0] a_iter;
    logic b_plus0, b_back, b_skip, b_active;
    logic [CW-1:0] b_iter;

    int checks = 0;
    int errors = 0;

    // Model: whether a loop is in progress and how many passes remain
    bit m_loop = 1'b0;
    int m_rem = 0;

    always #5 clk = ~clk;

    serv_mac_seq #(.W(1), .CW(CW), .NSTEP(2)) dut1 (
        .clk(clk), .i_rst(rst), .i_mac_first(mac_first), .i_mac_last(mac_last),
        .i_init(init), .i_cnt_en(cnt_en), .i_cnt0(cnt0), .i_cnt_done(cnt_done),
        .i_alu_cmp(alu_cmp), .i_rs1(rs1_1), .i_abort(abort),
        .o_pc_plus0(a_plus0), .o_pc_back(a_back), .o_pc_skip(a_skip),
        .o_active(a_active), .o_iter(a_iter)
    );

    serv_mac_seq #(.W(4), .CW(CW), .NSTEP(2)) dut4 (
        .clk(clk), .i_rst(rst), .i_mac_first(mac_first), .i_mac_last(mac_last),
        .i_init(init), .i_cnt_en(cnt_en), .i_cnt0(cnt0), .i_cnt_done(cnt_done),
        .i_alu_cmp(alu_cmp), .i_rs1(rs1_4), .i_abort(abort),
        .o_pc_plus0(b_plus0), .o_pc_back(b_back), .o_pc_skip(b_skip),
        .o_active(b_active), .o_iter(b_iter)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [2:0] expv);
        chk({tag, "_w1"}, {29'd0, a_plus0, a_back, a_skip}, {29'd0, expv});
        chk({tag, "_w4"}, {29'd0, b_plus0, b_back, b_skip}, {29'd0, expv});
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_active_w1"}, {31'd0, a_active}, {31'd0, m_loop});
        chk({tag, "_active_w4"}, {31'd0, b_active}, {31'd0, m_loop});
        chk({tag, "_iter_w1"}, {24'd0, a_iter}, m_rem);
        chk({tag, "_iter_w4"}, {24'd0, b_iter}, m_rem);
    endtask

    task automatic idle_bus();
        cnt_en = 1'b0; cnt0 = 1'b0; cnt_done = 1'b0; abort = 1'b0;
        mac_first = 1'b0; mac_last = 1'b0; init = 1'b0; alu_cmp = 1'b0;
    endtask

    task automatic drive_slot(input int s, input logic [31:0] rs1v);
        cnt_en   = 1'b1;
        cnt0     = (s == 0);
        cnt_done = (s == NS - 1);
        rs1_1    = rs1v[s];
        rs1_4    = rs1v[4 * (s % 8) +: 4];
    endtask

    // kind: 0 other, 1 step 1, 2 last step, 3 both decodes; abort_slot <0 means none
    task automatic run_instr(input int kind, input logic [31:0] rs1v, input bit cmpv,
                             input int abort_slot, input string tag);
        logic [2:0] exp_pc;
        bit nl;
        int nrem;
        bit aborted;
        exp_pc = PC_NONE;
        nl = m_loop;
        nrem = m_rem;
        aborted = 1'b0;
        if (kind == 1 && !m_loop) begin
            nrem = int'(rs1v[7:0]);
            if (nrem == 0) exp_pc = PC_SKIP;
            else begin exp_pc = PC_PLUS0; nl = 1'b1; end
        end else if (kind == 1 && m_loop) begin
            if (cmpv) begin exp_pc = PC_SKIP; nl = 1'b0; nrem = 0; end
        end else if (kind == 2 && m_loop) begin
            if (m_rem > 1) begin exp_pc = PC_BACK; nrem = m_rem - 1; end
            else begin nl = 1'b0; nrem = 0; end
        end
        mac_first = (kind == 1 || kind == 3);
        mac_last  = (kind == 2 || kind == 3);
        init = 1'b1;
        for (int s = 0; s < NS; s++) begin
            @(negedge clk);
            drive_slot(s, rs1v);
            alu_cmp = (s == NS - 1) ? cmpv : 1'($urandom);
            #1;
            chk_pc({tag, "_init_quiet"}, PC_NONE);
        end
        for (int s = 0; s < NS; s++) begin
            @(negedge clk);
            init = 1'b0;
            alu_cmp = 1'b0;
            drive_slot(s, rs1v);
            abort = (s == abort_slot);
            #1;
            if (abort) begin
                chk_pc({tag, "_abort_pc"}, PC_NONE);
                aborted = 1'b1;
                break;
            end
            chk_pc({tag, "_exec_pc"}, exp_pc);
        end
        @(negedge clk);
        idle_bus();
        if (aborted) begin nl = 1'b0; nrem = 0; end
        m_loop = nl;
        m_rem = nrem;
        #1;
        chk_state(tag);
    endtask

    task automatic run_passes(input int cmp_pass, input string tag, output int passes);
        passes = 0;
        while (m_loop && passes < 300) begin
            passes++;
            run_instr(1, $urandom, (passes == cmp_pass), -1, tag);
            if (m_loop) run_instr(2, $urandom, 1'b0, -1, tag);
        end
    endtask

    initial begin
        int passes;
        int kind;
        int ab;
        logic [31:0] rs1v;
        idle_bus();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_pc("reset_pc", PC_NONE);
        chk_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Count of 3: plus0 once, back on passes 1-2, fall through on pass 3
        run_instr(1, 32'd3, 1'b0, -1, "cnt3_load");
        run_passes(0, "cnt3", passes);
        chk("cnt3_passes", passes, 3);

        run_instr(1, 32'd0, 1'b0, -1, "cnt0_skip");

        // Bit 8 of rs1 lies outside the counter and must be ignored
        run_instr(1, 32'h0000_01F0, 1'b0, -1, "load_1f0");
        chk("iter_1f0_w1", {24'd0, a_iter}, 32'hF0);
        chk("iter_1f0_w4", {24'd0, b_iter}, 32'hF0);
        run_instr(2, 32'd0, 1'b0, 3, "abort_cleanup");

        run_instr(3, 32'd7, 1'b0, -1, "first_and_last");

        run_instr(1, 32'd5, 1'b0, -1, "cmp_load");
        run_passes(2, "cmp_exit", passes);
        chk("cmp_exit_passes", passes, 2);

        run_instr(1, 32'd4, 1'b0, -1, "abort_load");
        run_instr(1, 32'd0, 1'b0, -1, "abort_p1");
        run_instr(2, 32'd0, 1'b0, -1, "abort_p1");
        run_instr(1, 32'd0, 1'b0, -1, "abort_p2");
        run_instr(2, 32'd0, 1'b0, 5, "abort_mid");

        run_instr(1, 32'd4, 1'b0, -1, "abort_done_load");
        run_instr(1, 32'd0, 1'b0, -1, "abort_done_p1");
        run_instr(2, 32'd0, 1'b0, NS - 1, "abort_with_done");

        run_instr(1, 32'd2, 1'b0, -1, "mid_load");
        run_instr(1, 32'd0, 1'b0, -1, "mid_p1");
        run_instr(0, 32'd0, 1'b0, -1, "mid_step");
        run_instr(2, 32'd0, 1'b0, -1, "mid_p1_last");
        run_instr(1, 32'd0, 1'b0, -1, "mid_p2");
        run_instr(2, 32'd0, 1'b0, -1, "mid_p2_last");

        // Asynchronous reset in the middle of a last-step execute phase
        run_instr(1, 32'd6, 1'b0, -1, "arst_load");
        run_instr(1, 32'd0, 1'b0, -1, "arst_p1");
        mac_last = 1'b1;
        init = 1'b1;
        for (int s = 0; s < NS; s++) begin
            @(negedge clk);
            drive_slot(s, 32'd0);
        end
        @(negedge clk);
        init = 1'b0;
        drive_slot(0, 32'd0);
        #1;
        chk_pc("arst_pre_back", PC_BACK);
        #1 rst = 1'b1;
        #1;
        m_loop = 1'b0;
        m_rem = 0;
        chk_pc("arst_pc", PC_NONE);
        chk_state("arst");
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        rst = 1'b0;
        run_instr(1, 32'd2, 1'b0, -1, "arst_reload");
        run_passes(0, "arst_reload", passes);
        chk("arst_reload_passes", passes, 2);

        // Maximum count runs exactly 2^CW-1 passes
        run_instr(1, 32'hABCD_12FF, 1'b0, -1, "max_load");
        run_passes(0, "max", passes);
        chk("max_passes", passes, 255);

        for (int i = 0; i < 250; i++) begin
            kind = int'($urandom_range(0, 9));
            kind = (kind < 4) ? 1 : (kind < 7) ? 2 : (kind < 9) ? 0 : 3;
            rs1v = $urandom;
            rs1v[7:0] = 8'($urandom_range(0, 4));
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, NS - 1)) : -1;
            run_instr(kind, rs1v, ($urandom_range(0, 5) == 0), ab, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
